// File: rtl/pqr5_regfile_if.sv
// pqr5_regfile_if -- bus bundle for the pqr5 register file.
//   master : the pipeline side (drives read/write requests, consumes read data)
//   slave  : the register file itself
// Signals:
//   i_rf_rden0/1, i_rf_rs0/1_addr      : read enables and read addresses
//   i_rf_wren, i_rf_rdt_addr/data       : writeback port
//   o_rf_rs0/1_data                     : registered read data (1-cycle latency)
//   o_rf_init_busy                      : high while the post-reset clear sweep runs
interface pqr5_regfile_if #(
    parameter int XLEN = 32
);
    logic            i_rf_rden0;
    logic            i_rf_rden1;
    logic [4:0]      i_rf_rs0_addr;
    logic [4:0]      i_rf_rs1_addr;
    logic            i_rf_wren;
    logic [4:0]      i_rf_rdt_addr;
    logic [XLEN-1:0] i_rf_rdt_data;
    logic [XLEN-1:0] o_rf_rs0_data;
    logic [XLEN-1:0] o_rf_rs1_data;
    logic            o_rf_init_busy;

    modport master (
        output i_rf_rden0, i_rf_rden1, i_rf_rs0_addr, i_rf_rs1_addr,
               i_rf_wren, i_rf_rdt_addr, i_rf_rdt_data,
        input  o_rf_rs0_data, o_rf_rs1_data, o_rf_init_busy
    );

    modport slave (
        input  i_rf_rden0, i_rf_rden1, i_rf_rs0_addr, i_rf_rs1_addr,
               i_rf_wren, i_rf_rdt_addr, i_rf_rdt_data,
        output o_rf_rs0_data, o_rf_rs1_data, o_rf_init_busy
    );
endinterface

// File: rtl/pqr5_regfile.sv
// pqr5_regfile -- 32 x XLEN RISC-V style register file, two read ports, one write port.
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   rf  : pqr5_regfile_if.slave bundle (read ports 0/1, writeback, init busy)
// Behaviour:
//   After reset an INIT sweep zeroes x1..x31 (one register per cycle, 31 cycles),
//   o_rf_init_busy high throughout; writes are ignored and reads return zero
//   until READY. x0 is hardwired zero. Read data is registered (1-cycle latency)
//   and holds when the port's read enable is low.
// Configuration:
//   RF_WR_BYPASS_EN defined   : same-cycle write/read of one address returns the
//                               new write data (write-first).
//   RF_WR_BYPASS_EN undefined : returns the old register contents (read-first).

// One read lane: output register with hold, zero during the clear sweep.
module pqr5_regfile_rport #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            busy,
    input  logic            rden,
    input  logic [XLEN-1:0] rd_val,
    output logic [XLEN-1:0] rdata
);
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (rden)
            rdata <= busy ? '0 : rd_val;
    end
endmodule

module pqr5_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    pqr5_regfile_if.slave   rf
);
    localparam int NUM_RD = 2;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t                       state_q, state_d;
    logic [4:0]                   ptr_q;
    logic                         init_busy;
    logic                         wr_fire;
    logic [XLEN-1:0]              regs [1:31];

    logic [NUM_RD-1:0]            rden;
    logic [NUM_RD-1:0][4:0]       raddr;
    logic [NUM_RD-1:0][XLEN-1:0]  rd_val;
    logic [NUM_RD-1:0][XLEN-1:0]  rdata;

    assign rden  = {rf.i_rf_rden1, rf.i_rf_rden0};
    assign raddr = {rf.i_rf_rs1_addr, rf.i_rf_rs0_addr};
    assign rf.o_rf_rs0_data  = rdata[0];
    assign rf.o_rf_rs1_data  = rdata[1];
    assign rf.o_rf_init_busy = init_busy;

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_INIT;
        else
            state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && ptr_q == 5'd31)
            state_d = S_READY;
    end

    // ---- FSM: outputs ----
    always_comb begin
        init_busy = (state_q == S_INIT);
    end

    // Sweep pointer starts at 1: x0 has no storage.
    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= 5'd1;
        else if (init_busy && ptr_q != 5'd31)
            ptr_q <= ptr_q + 5'd1;
    end

    assign wr_fire = rf.i_rf_wren && !init_busy && (rf.i_rf_rdt_addr != 5'd0);

    // Storage has no reset of its own; the sweep clears it. rst blocks both
    // the sweep write and the writeback so reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_busy)
                regs[ptr_q] <= '0;
            else if (wr_fire)
                regs[rf.i_rf_rdt_addr] <= rf.i_rf_rdt_data;
        end
    end

    // Per-lane read value selection (x0 zero, optional write-first bypass).
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_val[p] = '0;
            if (raddr[p] != 5'd0) begin
                rd_val[p] = regs[raddr[p]];
`ifdef RF_WR_BYPASS_EN
                if (wr_fire && rf.i_rf_rdt_addr == raddr[p])
                    rd_val[p] = rf.i_rf_rdt_data;
`else
`endif
            end
        end
    end

    pqr5_regfile_rport #(.XLEN(XLEN)) u_rport [NUM_RD-1:0] (
        .clk    (clk),
        .rst    (rst),
        .busy   (init_busy),
        .rden   (rden),
        .rd_val (rd_val),
        .rdata  (rdata)
    );
endmodule

// File: tb/tb_pqr5_regfile.sv
// tb_pqr5_regfile -- directed bench for pqr5_regfile. Stimulus pushes the
// expected read data per port into a queue; a monitor pops on each cycle
// after an enabled read and compares the registered outputs every cycle
// (which also covers hold behaviour and reset clearing).
module tb_pqr5_regfile;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pqr5_regfile_if #(.XLEN(XLEN)) rf_if ();

    pqr5_regfile #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_if)
    );

    int checks = 0;
    int fails  = 0;

    logic [XLEN-1:0] q0[$];
    logic [XLEN-1:0] q1[$];

    logic       rst_seen = 1'b0;
    logic [1:0] rd_seen  = 2'b00;

`ifdef RF_WR_BYPASS_EN
    localparam logic [XLEN-1:0] EXP_SAME = 32'h22;
`else
    localparam logic [XLEN-1:0] EXP_SAME = 32'h11;
`endif

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_if.i_rf_rden0    = 1'b0;
        rf_if.i_rf_rden1    = 1'b0;
        rf_if.i_rf_rs0_addr = 5'd0;
        rf_if.i_rf_rs1_addr = 5'd0;
        rf_if.i_rf_wren     = 1'b0;
        rf_if.i_rf_rdt_addr = 5'd0;
        rf_if.i_rf_rdt_data = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [XLEN-1:0] d);
        rf_if.i_rf_wren     = 1'b1;
        rf_if.i_rf_rdt_addr = a;
        rf_if.i_rf_rdt_data = d;
    endtask

    task automatic rd0(input logic [4:0] a, input logic [XLEN-1:0] e);
        rf_if.i_rf_rden0    = 1'b1;
        rf_if.i_rf_rs0_addr = a;
        if (!rst) q0.push_back(e);
    endtask

    task automatic rd1(input logic [4:0] a, input logic [XLEN-1:0] e);
        rf_if.i_rf_rden1    = 1'b1;
        rf_if.i_rf_rs1_addr = a;
        if (!rst) q1.push_back(e);
    endtask

    // Count busy cycles from the first cycle after rst drops; expect 31.
    task automatic sweep_count(input string name);
        int cnt;
        cnt = 0;
        chk({name, "_busy_start"}, {31'd0, rf_if.o_rf_init_busy}, 32'd1);
        while (rf_if.o_rf_init_busy && cnt < 64) begin
            idle();
            if (cnt == 3) begin
                wr(5'd3, 32'hA);
                rd0(5'd3, 32'h0);
            end
            step();
            cnt++;
        end
        idle();
        chk({name, "_busy_cycles"}, cnt, 32'd31);
    endtask

    always @(posedge clk) begin
        rst_seen <= rst;
        rd_seen  <= {rf_if.i_rf_rden1, rf_if.i_rf_rden0};
    end

    // Monitor: track the value each output must currently hold.
    initial begin
        logic [XLEN-1:0] cur0, cur1;
        cur0 = '0;
        cur1 = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                cur0 = '0;
                cur1 = '0;
            end else begin
                if (rd_seen[0]) begin
                    if (q0.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL rs0_pop: got empty queue expected entry at %0t", $time);
                    end else cur0 = q0.pop_front();
                end
                if (rd_seen[1]) begin
                    if (q1.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL rs1_pop: got empty queue expected entry at %0t", $time);
                    end else cur1 = q1.pop_front();
                end
            end
            chk("rs0_data", rf_if.o_rf_rs0_data, cur0);
            chk("rs1_data", rf_if.o_rf_rs1_data, cur1);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;

        // Clear sweep, with an ignored write and a zero read during INIT.
        sweep_count("init1");

        // All registers read back zero on both ports.
        for (int i = 1; i < 32; i++) begin
            idle();
            rd0(i[4:0], 32'h0);
            rd1(5'(32 - i), 32'h0);
            step();
        end
        idle();

        // Write then read with 1-cycle latency, then hold.
        wr(5'd5, 32'hDEADBEEF);
        step(); idle();
        rd0(5'd5, 32'hDEADBEEF);
        step(); idle();
        rf_if.i_rf_rs0_addr = 5'd9;
        step(); step();

        // x0 write is dropped; same-cycle read of x0 too.
        wr(5'd0, 32'h12345678);
        rd1(5'd0, 32'h0);
        step(); idle();
        rd0(5'd0, 32'h0);
        rd1(5'd0, 32'h0);
        step(); idle();

        // Same-cycle write/read collision on x7, both ports.
        wr(5'd7, 32'h11);
        step(); idle();
        wr(5'd7, 32'h22);
        rd0(5'd7, EXP_SAME);
        rd1(5'd7, EXP_SAME);
        step(); idle();
        rd1(5'd7, 32'h22);
        step(); idle();

        // Independent ports, extreme data patterns.
        wr(5'd10, 32'hA5A5A5A5);
        step(); idle();
        wr(5'd31, 32'hFFFFFFFF);
        rd0(5'd10, 32'hA5A5A5A5);
        step(); idle();
        rd0(5'd31, 32'hFFFFFFFF);
        rd1(5'd10, 32'hA5A5A5A5);
        step(); idle();
        rd0(5'd5, 32'hDEADBEEF);
        step(); idle();
        step();

        // Reset mid-sweep: sweep restarts, reset beats a read and a write.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("sweep1_busy", {31'd0, rf_if.o_rf_init_busy}, 32'd1);
            step();
        end
        rst = 1'b1;
        rd0(5'd5, 32'h0);
        rd1(5'd7, 32'h0);
        wr(5'd6, 32'h66);
        step(); idle();
        rst = 1'b0;
        sweep_count("init2");

        rd0(5'd5, 32'h0);
        rd1(5'd31, 32'h0);
        step(); idle();
        rd0(5'd6, 32'h0);
        rd1(5'd7, 32'h0);
        step(); idle();
        step(); step(); step();

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
